// File: rtl/dual_port_ram_fifo_ctrl_if.sv
// Producer/consumer interface of the FIFO controller.
//
// Handshake: push and pop are requests sampled on the rising clock edge.
// A push is accepted when full is low and a pop is accepted when empty is low,
// so ~full and ~empty act as the ready signals. A rejected request is dropped
// and reported by a one-cycle overflow or underflow pulse. pop_valid is high
// in the cycle after an accepted pop, and pop_data is meaningful only while
// pop_valid is high.
//
// Signals: push, push_data, pop (client -> FIFO);
//          pop_data, pop_valid, full, empty, almost_full, count,
//          overflow, underflow (FIFO -> client).
// Modports: master = client side, slave = controller side.
interface dual_port_ram_fifo_ctrl_if #(
  parameter int ADDR_WIDTH = 4,
  parameter int DATA_WIDTH = 8
);
  logic                  push;
  logic [DATA_WIDTH-1:0] push_data;
  logic                  pop;
  logic [DATA_WIDTH-1:0] pop_data;
  logic                  pop_valid;
  logic                  full;
  logic                  empty;
  logic                  almost_full;
  logic [ADDR_WIDTH:0]   count;
  logic                  overflow;
  logic                  underflow;

  modport master (
    output push, push_data, pop,
    input  pop_data, pop_valid, full, empty, almost_full, count,
           overflow, underflow
  );

  modport slave (
    input  push, push_data, pop,
    output pop_data, pop_valid, full, empty, almost_full, count,
           overflow, underflow
  );
endinterface

// File: rtl/dual_port_ram_fifo_ctrl.sv
// Sequences an external dual-port RAM as a synchronous FIFO.
// Port 0 of the RAM is the write port, port 1 the read port (registered
// read data, one cycle latency).
//
// Ports:
//   clk, rst          clock, asynchronous active-high reset
//   fifo              producer/consumer interface (slave modport)
//   ram_wr_en         RAM wr_en
//   ram_port_en_0     RAM port_en_0
//   ram_addr_0        RAM addr_in_0 (write pointer address)
//   ram_data_in       RAM data_in (push_data passthrough)
//   ram_port_en_1     RAM port_en_1
//   ram_addr_1        RAM addr_in_1 (read pointer address)
//   ram_data_out_1    RAM data_out_1 (returned as pop_data)
module dual_port_ram_fifo_ctrl #(
  parameter int ADDR_WIDTH = 4,
  parameter int DATA_WIDTH = 8,
  parameter int DEPTH      = 16,
  parameter int AF_LEVEL   = 12
) (
  input  logic                  clk,
  input  logic                  rst,
  dual_port_ram_fifo_ctrl_if.slave fifo,
  output logic                  ram_wr_en,
  output logic                  ram_port_en_0,
  output logic [ADDR_WIDTH-1:0] ram_addr_0,
  output logic [DATA_WIDTH-1:0] ram_data_in,
  output logic                  ram_port_en_1,
  output logic [ADDR_WIDTH-1:0] ram_addr_1,
  input  logic [DATA_WIDTH-1:0] ram_data_out_1
);

  localparam logic [ADDR_WIDTH:0] PTR_ONE  = {{ADDR_WIDTH{1'b0}}, 1'b1};
  localparam logic [ADDR_WIDTH:0] DEPTH_L  = (ADDR_WIDTH+1)'(DEPTH);
  localparam logic [ADDR_WIDTH:0] AF_L     = (ADDR_WIDTH+1)'(AF_LEVEL);

  // Pointers carry an extra wrap bit so full (difference == DEPTH) and
  // empty (difference == 0) are distinguishable.
  logic [ADDR_WIDTH:0] wr_ptr;
  logic [ADDR_WIDTH:0] rd_ptr;
  logic [ADDR_WIDTH:0] count_w;
  logic                push_acc;
  logic                pop_acc;
  logic                full_w;
  logic                empty_w;
  logic                pop_valid_q;
  logic                overflow_q;
  logic                underflow_q;

  // Occupancy is a pure function of the registered pointers.
  assign count_w = wr_ptr - rd_ptr;
  assign full_w  = (count_w == DEPTH_L);
  assign empty_w = (count_w == '0);

  // Gating on full/empty means a read never targets the slot written in the
  // same cycle: at empty the pop is refused, at full the push is refused.
  assign push_acc = fifo.push & ~full_w;
  assign pop_acc  = fifo.pop  & ~empty_w;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr      <= '0;
      rd_ptr      <= '0;
      pop_valid_q <= 1'b0;
      overflow_q  <= 1'b0;
      underflow_q <= 1'b0;
    end else begin
      if (push_acc) wr_ptr <= wr_ptr + PTR_ONE;
      if (pop_acc)  rd_ptr <= rd_ptr + PTR_ONE;
      pop_valid_q <= pop_acc;
      overflow_q  <= fifo.push & full_w;
      underflow_q <= fifo.pop & empty_w;
    end
  end

  assign ram_wr_en     = push_acc;
  assign ram_port_en_0 = push_acc;
  assign ram_addr_0    = wr_ptr[ADDR_WIDTH-1:0];
  assign ram_data_in   = fifo.push_data;
  assign ram_port_en_1 = pop_acc;
  assign ram_addr_1    = rd_ptr[ADDR_WIDTH-1:0];

  assign fifo.pop_data    = ram_data_out_1;
  assign fifo.pop_valid   = pop_valid_q;
  assign fifo.full        = full_w;
  assign fifo.empty       = empty_w;
  assign fifo.almost_full = (count_w >= AF_L);
  assign fifo.count       = count_w;
  assign fifo.overflow    = overflow_q;
  assign fifo.underflow   = underflow_q;

endmodule
